// File: rtl/autoc_pkg.sv
// rtl/autoc_pkg.sv - shared state encoding and width check for the autocorrelation run controller
package autoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam int ACC_WIDTH_DEFAULT = 40;

    // The accumulator needs one guard bit beyond a full product.
    function automatic bit acc_width_ok(input int acc_width, input int width);
        return acc_width >= 2 * width + 1;
    endfunction

endpackage

// File: rtl/autoc_if.sv
// rtl/autoc_if.sv - run-control and product bus between host/datapath and autoc_ctrl
interface autoc_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int LEN_WIDTH = 16
);
    logic                        start;
    logic                        abort;
    logic [LEN_WIDTH-1:0]        warmup_len;
    logic [LEN_WIDTH-1:0]        window_len;
    logic signed [ACC_WIDTH-1:0] threshold;
    logic signed [2*WIDTH-1:0]   prod_in;
    logic                        prod_strobe;
    logic                        dp_enable;
    logic                        busy;
    logic                        done;
    logic signed [ACC_WIDTH-1:0] acc_out;
    logic                        detect;
    logic                        overflow;

    modport master (
        output start, abort, warmup_len, window_len, threshold, prod_in, prod_strobe,
        input  dp_enable, busy, done, acc_out, detect, overflow
    );

    modport slave (
        input  start, abort, warmup_len, window_len, threshold, prod_in, prod_strobe,
        output dp_enable, busy, done, acc_out, detect, overflow
    );
endinterface

// File: rtl/autoc_sat_acc.sv
// rtl/autoc_sat_acc.sv - signed saturating accumulator with clear, add enable and sticky overflow
module autoc_sat_acc #(
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        add_en,
    input  logic signed [IN_WIDTH-1:0]  add_val,
    output logic signed [ACC_WIDTH-1:0] sum_d,
    output logic signed [ACC_WIDTH-1:0] sum_q,
    output logic                        ovf_d,
    output logic                        ovf_q
);
    logic [ACC_WIDTH:0] wide;

    always_comb begin
        // One extra bit makes any overflow visible as a disagreement of the top two bits.
        wide  = {sum_q[ACC_WIDTH-1], sum_q}
              + {{(ACC_WIDTH+1-IN_WIDTH){add_val[IN_WIDTH-1]}}, add_val};
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (clr) begin
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (add_en) begin
            if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
                sum_d = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                ovf_d = 1'b1;
            end else begin
                sum_d = wide[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: rtl/autoc_ctrl.sv
// rtl/autoc_ctrl.sv - run FSM: gates the delay-multiply stage, discards warmup, accumulates and reports
module autoc_ctrl
    import autoc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter int LEN_WIDTH = 16
) (
    input  logic   clk,
    input  logic   reset_n,
    autoc_if.slave bus
);
    if (!acc_width_ok(ACC_WIDTH, WIDTH)) begin : g_acc_width_check
        $error("autoc_ctrl: ACC_WIDTH must be at least 2*WIDTH+1");
    end

    state_e                      state_q, state_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]        warm_q, warm_d;
    logic [LEN_WIDTH-1:0]        win_q, win_d;
    logic signed [ACC_WIDTH-1:0] thr_q, thr_d, thr_eff;
    logic signed [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic                        detect_q, detect_d;
    logic                        overflow_q, overflow_d;
    logic                        done_q, done_d;
    logic                        dp_enable_q, dp_enable_d;
    logic                        busy_q, busy_d;
    logic                        acc_clr, acc_add;
    logic signed [ACC_WIDTH-1:0] acc_sum_d, acc_sum_q;
    logic                        acc_ovf_d, acc_ovf_q;

    autoc_sat_acc #(
        .IN_WIDTH (2*WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_acc (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (acc_clr),
        .add_en (acc_add),
        .add_val(bus.prod_in),
        .sum_d  (acc_sum_d),
        .sum_q  (acc_sum_q),
        .ovf_d  (acc_ovf_d),
        .ovf_q  (acc_ovf_q)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        warm_d     = warm_q;
        win_d      = win_q;
        thr_d      = thr_q;
        thr_eff    = thr_q;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        acc_out_d  = acc_out_q;
        detect_d   = detect_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    warm_d  = bus.warmup_len;
                    win_d   = bus.window_len;
                    thr_d   = bus.threshold;
                    thr_eff = bus.threshold;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                    if (bus.warmup_len != '0)      state_d = ST_WARMUP;
                    else if (bus.window_len != '0) state_d = ST_ACCUM;
                    else                           state_d = ST_REPORT;
                end
            end
            ST_WARMUP: begin
                cnt_d = cnt_q + LEN_WIDTH'(1);
                if (cnt_d == warm_q) begin
                    cnt_d   = '0;
                    state_d = (win_q != '0) ? ST_ACCUM : ST_REPORT;
                end
            end
            ST_ACCUM: begin
                if (bus.prod_strobe) begin
                    acc_add = 1'b1;
                    cnt_d   = cnt_q + LEN_WIDTH'(1);
                    if (cnt_d == win_q) state_d = ST_REPORT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && bus.abort) begin
            state_d = ST_IDLE;
            acc_add = 1'b0;
        end

        // Results are captured from the accumulator's next value so they are valid with done.
        if (state_d == ST_REPORT) begin
            done_d     = 1'b1;
            acc_out_d  = acc_sum_d;
            detect_d   = (acc_sum_d >= thr_eff);
            overflow_d = acc_ovf_d;
        end

        dp_enable_d = (state_d == ST_WARMUP) || (state_d == ST_ACCUM);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            warm_q      <= '0;
            win_q       <= '0;
            thr_q       <= '0;
            acc_out_q   <= '0;
            detect_q    <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            dp_enable_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            win_q       <= win_d;
            thr_q       <= thr_d;
            acc_out_q   <= acc_out_d;
            detect_q    <= detect_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            dp_enable_q <= dp_enable_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dp_enable = dp_enable_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.detect    = detect_q;
    assign bus.overflow  = overflow_q;
endmodule
